uart_keycode_rx: RTL

- Receive-side counterpart of the keycode UART link: pops bytes from the UART RX FIFO and parses 4-byte keycode frames sent by the remote board.
- Emits a validated 16-bit PS/2 keycode plus a one-cycle strobe. Output feeds the remote-player bin2ascii/key_decoder path.
- Counts framing, checksum and timeout errors. Resynchronises on the next sync byte.

---
 rtl/uart_keycode_rx_pkg.sv | 24 ++
 rtl/uart_keycode_rx_if.sv | 14 +
 rtl/uart_keycode_rx_timer.sv | 39 +++
 rtl/uart_keycode_rx.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/uart_keycode_rx_pkg.sv
// uart_keycode_pkg: shared definitions for the keycode UART receiver.
//   keyrx_state_t  : frame parser states
//   SYNC_BYTE_DEF  : default frame start marker
//   FRAME_LEN      : bytes per frame (SYNC, HI, LO, CHK)
//   keyrx_chk()    : frame checksum, SYNC ^ HI ^ LO
package uart_keycode_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GET_HI,
      GET_LO,
      GET_CHK
   } keyrx_state_t;

   localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
   localparam int unsigned FRAME_LEN     = 4;

   function automatic logic [7:0] keyrx_chk(input logic [7:0] hi,
                                            input logic [7:0] lo,
                                            input logic [7:0] sync = SYNC_BYTE_DEF);
      return sync ^ hi ^ lo;
   endfunction

endpackage

// File: rtl/uart_keycode_rx_if.sv
// uart_keycode_rx_if: UART RX FIFO read port.
//   rx_empty : FIFO empty flag (FIFO -> reader)
//   r_data   : FIFO head byte, valid while rx_empty=0 (FIFO -> reader)
//   rd_uart  : pop strobe (reader -> FIFO)
// modport master : the reader that pops bytes (uart_keycode_rx)
// modport slave  : the FIFO side
interface uart_keycode_rx_if;
   logic       rx_empty;
   logic [7:0] r_data;
   logic       rd_uart;

   modport master (input rx_empty, input r_data, output rd_uart);
   modport slave  (output rx_empty, output r_data, input rd_uart);
endinterface

// File: rtl/uart_keycode_rx_timer.sv
// keyrx_timer: clear/enable down-counter with a one-cycle expire pulse.
//   clk, rst : clock, asynchronous active-high reset (counter -> 0)
//   clr      : reload to LIMIT (has priority over en)
//   en       : count down one step this cycle
//   expire   : high on the edge that would take the count from 1 to 0,
//              i.e. the LIMIT-th enabled cycle after a clear; suppressed by clr
// The counter parks at 0 after expiry, so expire fires once per clear.
module keyrx_timer #(
   parameter int unsigned LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int unsigned W = $clog2(LIMIT + 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = W'(LIMIT);
      else if (en && (cnt_q != '0))
         cnt_d = cnt_q - W'(1);
   end

   assign expire = en && !clr && (cnt_q == W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_keycode_rx.sv
// uart_keycode_rx: pops the UART RX FIFO and parses 4-byte keycode frames
// {SYNC_BYTE, HI, LO, CHK}, CHK = SYNC_BYTE ^ HI ^ LO.
//   clk, rst   : clock, asynchronous active-high reset
//   fifo       : RX FIFO read port (rx_empty, r_data, rd_uart)
//   keycode    : last accepted keycode {hi,lo}
//   key_valid  : one-cycle strobe, keycode just updated
//   frame_err  : one-cycle strobe, checksum mismatch or intra-frame timeout
//   err_count  : saturating count of frame_err events
//   link_ok    : remote link alive
// Optional link monitor: define UART_KEYCODE_RX_LINK_MON_EN. When enabled,
// LINK_TIMEOUT_CYCLES without an accepted frame drops link_ok and clears
// keycode; otherwise link_ok is 1 after reset and keycode is held.
module uart_keycode_rx
   import uart_keycode_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE           = SYNC_BYTE_DEF,
   parameter int unsigned TIMEOUT_CYCLES      = 650_000,
   parameter int unsigned ERR_CNT_W           = 8,
   parameter int unsigned LINK_TIMEOUT_CYCLES = 65_000_000
) (
   input  logic                 clk,
   input  logic                 rst,
   uart_keycode_rx_if.master    fifo,
   output logic [15:0]          keycode,
   output logic                 key_valid,
   output logic                 frame_err,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic                 link_ok
);

   keyrx_state_t         state_q, state_d;
   logic [7:0]           hi_q, hi_d, lo_q, lo_d;
   logic [15:0]          keycode_q, keycode_d;
   logic                 key_valid_q, key_valid_d;
   logic                 frame_err_q, frame_err_d;
   logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
   logic                 link_ok_q, link_ok_d;

   logic pop, frame_ok, byte_tmo, link_tmo, link_clr, link_en;

   assign pop          = !fifo.rx_empty;
   assign fifo.rd_uart = pop;
   assign frame_ok     = pop && (state_q == GET_CHK) &&
                         (fifo.r_data == keyrx_chk(hi_q, lo_q, SYNC_BYTE));

   // Held in reload while IDLE so every frame starts with a full budget.
   keyrx_timer #(.LIMIT(TIMEOUT_CYCLES)) u_byte_tmr (
      .clk    (clk),
      .rst    (rst),
      .clr    (pop || (state_q == IDLE)),
      .en     (state_q != IDLE),
      .expire (byte_tmo)
   );

`ifdef UART_KEYCODE_RX_LINK_MON_EN
   assign link_clr = frame_ok;
   assign link_en  = 1'b1;
`else
   // Link monitor compiled out: timer held in reload, never expires.
   assign link_clr = 1'b1;
   assign link_en  = 1'b0;
`endif

   keyrx_timer #(.LIMIT(LINK_TIMEOUT_CYCLES)) u_link_tmr (
      .clk    (clk),
      .rst    (rst),
      .clr    (link_clr),
      .en     (link_en),
      .expire (link_tmo)
   );

   always_comb begin
      state_d     = state_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      keycode_d   = keycode_q;
      key_valid_d = 1'b0;
      frame_err_d = 1'b0;
      err_count_d = err_count_q;
      link_ok_d   = link_ok_q;

      // A consumed byte takes priority over a same-cycle timeout.
      if (pop) begin
         case (state_q)
            IDLE:    if (fifo.r_data == SYNC_BYTE) state_d = GET_HI;
            GET_HI:  begin hi_d = fifo.r_data; state_d = GET_LO; end
            GET_LO:  begin lo_d = fifo.r_data; state_d = GET_CHK; end
            GET_CHK: begin
               state_d = IDLE;
               if (frame_ok) begin
                  keycode_d   = {hi_q, lo_q};
                  key_valid_d = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (byte_tmo) begin
         state_d     = IDLE;
         frame_err_d = 1'b1;
      end

      if (frame_err_d && (err_count_q != '1))
         err_count_d = err_count_q + ERR_CNT_W'(1);

`ifdef UART_KEYCODE_RX_LINK_MON_EN
      if (frame_ok)
         link_ok_d = 1'b1;
      else if (link_tmo) begin
         link_ok_d = 1'b0;
         keycode_d = '0;
      end
`else
      link_ok_d = 1'b1;
      if (link_tmo)
         keycode_d = '0;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         hi_q        <= '0;
         lo_q        <= '0;
         keycode_q   <= '0;
         key_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         err_count_q <= '0;
         link_ok_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         keycode_q   <= keycode_d;
         key_valid_q <= key_valid_d;
         frame_err_q <= frame_err_d;
         err_count_q <= err_count_d;
         link_ok_q   <= link_ok_d;
      end
   end

   assign keycode   = keycode_q;
   assign key_valid = key_valid_q;
   assign frame_err = frame_err_q;
   assign err_count = err_count_q;
   assign link_ok   = link_ok_q;

endmodule
